// File: rtl/fa_bist_checker_if.sv
// Signal bundle between fa_bist_checker and its host / the full_adder under test.
// master: the BIST sequencer; slave: host logic and the adder it exercises.
interface fa_bist_checker_if;
    logic       start;
    logic       input1;
    logic       input2;
    logic       input3;
    logic       sum;
    logic       count;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [2:0] fail_vec;

    modport master (
        input  start, sum, count,
        output input1, input2, input3, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, sum, count,
        input  input1, input2, input3, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/fa_bist_checker.sv
// Exhaustive 8-vector BIST sequencer for a 1-bit full adder.
// Optional FA_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module fa_bist_checker #(
    parameter int unsigned SETTLE = 0
) (
    input logic              clk,
    input logic              rst,
    fa_bist_checker_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [3:0] SettleW = SETTLE[3:0];

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] in_q, in_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_q, err_d;
    logic [2:0] fail_q, fail_d;

    logic [1:0] ones;
    logic       mismatch;
    logic [3:0] err_inc;
    logic       last_vec;

    // ones[0] is the golden sum, ones[1] the golden carry (majority)
    assign ones     = {1'b0, in_q[2]} + {1'b0, in_q[1]} + {1'b0, in_q[0]};
    assign mismatch = (bus.sum != ones[0]) || (bus.count != ones[1]);
    assign err_inc  = err_q + {3'b000, mismatch};

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        tcnt_d   = tcnt_q;
        in_d     = in_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        last_vec = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    vec_d   = 3'd0;
                    in_d    = 3'd0;
                    tcnt_d  = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 4'd0;
                    fail_d  = 3'd0;
                end
            end
            StRun: begin
                if (tcnt_q < SettleW) begin
                    tcnt_d = tcnt_q + 4'd1;
                end else begin
                    if (mismatch) begin
                        err_d = err_inc;
                        if (err_q == 4'd0) fail_d = vec_q;
                    end
`ifdef FA_BIST_STOP_ON_FAIL_EN
                    last_vec = (vec_q == 3'd7) || mismatch;
`else
                    last_vec = (vec_q == 3'd7);
`endif
                    tcnt_d = 4'd0;
                    if (last_vec) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == 4'd0);
                        in_d    = 3'd0;
                    end else begin
                        vec_d = vec_q + 3'd1;
                        in_d  = vec_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= 3'd0;
            tcnt_q  <= 4'd0;
            in_q    <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            fail_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            tcnt_q  <= tcnt_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.input1   = in_q[2];
    assign bus.input2   = in_q[1];
    assign bus.input3   = in_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: SETTLE=0 and SETTLE=2 instances run side by side against a
// table-driven adder model (correct, stuck, inverted, random faults).
module tb_fa_bist_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] sum_tab;
    logic [7:0] cnt_tab;

    fa_bist_checker_if if0 ();
    fa_bist_checker_if if2 ();

    fa_bist_checker #(.SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    fa_bist_checker #(.SETTLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));

    always #5 clk = ~clk;

    assign if0.sum   = sum_tab[{if0.input1, if0.input2, if0.input3}];
    assign if0.count = cnt_tab[{if0.input1, if0.input2, if0.input3}];
    assign if2.sum   = sum_tab[{if2.input1, if2.input2, if2.input3}];
    assign if2.count = cnt_tab[{if2.input1, if2.input2, if2.input3}];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0 correct, 1 sum stuck-at-0, 2 count inverted, 3 random flips
    task automatic set_tables(input int mode);
        for (int v = 0; v < 8; v++) begin
            int ones;
            ones = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            sum_tab[v] = (ones % 2) == 1;
            cnt_tab[v] = ones >= 2;
            if (mode == 1) sum_tab[v] = 1'b0;
            if (mode == 2) cnt_tab[v] = ~cnt_tab[v];
            if (mode == 3) begin
                if ($urandom_range(0, 4) == 0) sum_tab[v] = ~sum_tab[v];
                if ($urandom_range(0, 4) == 0) cnt_tab[v] = ~cnt_tab[v];
            end
        end
    endtask

    // Expected run outcome from the adder truth table; d = edges from start to done
    function automatic void model(input int s, output int d, output int e, output int f,
                                  output int p);
        int  ones;
        int  last;
        bit  mis;
        bit  stopped;
        last = 7;
        stopped = 1'b0;
        e = 0;
        f = 0;
        for (int v = 0; v < 8; v++) begin
            ones = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            mis  = (sum_tab[v] != ((ones % 2) == 1)) || (cnt_tab[v] != (ones >= 2));
            if (!stopped && mis) begin
                if (e == 0) f = v;
                e++;
`ifdef FA_BIST_STOP_ON_FAIL_EN
                stopped = 1'b1;
                last = v;
`endif
            end
        end
        d = (last + 1) * (s + 1);
        p = (e == 0) ? 1 : 0;
    endfunction

    task automatic chk_inst(input string tag, input int j, input int s, input int d,
                            input logic busy, input logic done, input logic [2:0] vin);
        int exp_vec;
        exp_vec = (j < d) ? j / (s + 1) : 0;
        chk($sformatf("%s S%0d j%0d busy", tag, s, j), 8'(busy), 8'(j < d));
        chk($sformatf("%s S%0d j%0d done", tag, s, j), 8'(done), 8'(j >= d));
        chk($sformatf("%s S%0d j%0d vec", tag, s, j), 8'(vin), 8'(exp_vec));
    endtask

    task automatic run_and_check(input string tag, input int restart_at);
        int d0, e0, f0, p0, d2, e2, f2, p2;
        model(0, d0, e0, f0, p0);
        model(2, d2, e2, f2, p2);
        @(negedge clk);
        if0.start = 1'b1;
        if2.start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 27; j++) begin
            @(negedge clk);
            if0.start = (restart_at == j + 1);
            if2.start = (restart_at == j + 1);
            chk_inst(tag, j, 0, d0, if0.busy, if0.done, {if0.input1, if0.input2, if0.input3});
            chk_inst(tag, j, 2, d2, if2.busy, if2.done, {if2.input1, if2.input2, if2.input3});
            if (j == 0) begin
                chk({tag, " S0 cleared err"}, 8'(if0.err_cnt), 8'd0);
                chk({tag, " S2 cleared err"}, 8'(if2.err_cnt), 8'd0);
            end
        end
        if0.start = 1'b0;
        if2.start = 1'b0;
        chk({tag, " S0 err_cnt"}, 8'(if0.err_cnt), 8'(e0));
        chk({tag, " S0 fail_vec"}, 8'(if0.fail_vec), 8'(f0));
        chk({tag, " S0 pass"}, 8'(if0.pass), 8'(p0));
        chk({tag, " S2 err_cnt"}, 8'(if2.err_cnt), 8'(e2));
        chk({tag, " S2 fail_vec"}, 8'(if2.fail_vec), 8'(f2));
        chk({tag, " S2 pass"}, 8'(if2.pass), 8'(p2));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " S0 busy"}, 8'(if0.busy), 8'd0);
        chk({tag, " S0 done"}, 8'(if0.done), 8'd0);
        chk({tag, " S0 err"}, 8'(if0.err_cnt), 8'd0);
        chk({tag, " S0 vec"}, 8'({if0.input1, if0.input2, if0.input3}), 8'd0);
        chk({tag, " S2 busy"}, 8'(if2.busy), 8'd0);
        chk({tag, " S2 done"}, 8'(if2.done), 8'd0);
        chk({tag, " S2 err"}, 8'(if2.err_cnt), 8'd0);
        chk({tag, " S2 vec"}, 8'({if2.input1, if2.input2, if2.input3}), 8'd0);
    endtask

    initial begin
        if0.start = 1'b0;
        if2.start = 1'b0;
        set_tables(0);

        // Reset state, with start held high to show reset dominates
        rst = 1'b1;
        @(negedge clk);
        if0.start = 1'b1;
        if2.start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        if2.start = 1'b0;
        chk_idle("reset");
        chk("reset S0 pass", 8'(if0.pass), 8'd0);
        chk("reset S0 fail_vec", 8'(if0.fail_vec), 8'd0);
        rst = 1'b0;
        @(negedge clk);

        run_and_check("good_restart_ignored", 3);
        run_and_check("good_from_done", 0);

        set_tables(1);
        run_and_check("sum_stuck0", 0);

        set_tables(2);
        run_and_check("count_inv", 0);

        // Reset asserted at edge k+4 of a run
        set_tables(0);
        @(negedge clk);
        if0.start = 1'b1;
        if2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        if2.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midrun_rst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle($sformatf("after_rst%0d", i));
        end

        for (int r = 0; r < 6; r++) begin
            set_tables(3);
            run_and_check($sformatf("random%0d", r), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fa_bist_checker.md
# fa_bist_checker

Synthesizable built-in self-test sequencer for the 1-bit `full_adder`. It drives the adder's three inputs through all 8 vectors, checks `sum`/`count` against the golden result, and reports pass/fail, error count and first failing vector. It is the hardware counterpart of the bench-side stimulus: it runs on-chip beside `full_adder` and is started by a single pulse.

## Interface
- `SETTLE`, default 0: extra wait cycles per vector before sampling, 0..15.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins a run; honoured in IDLE or DONE only.
- `input1` output 1: adder input, vector bit 2 (MSB); registered.
- `input2` output 1: adder input, vector bit 1; registered.
- `input3` output 1: adder input, vector bit 0 (LSB); registered.
- `sum` input 1: adder sum output under test.
- `count` input 1: adder carry output under test.
- `busy` output 1: high while a run is in progress.
- `done` output 1: high from run completion until next `start` or `rst`.
- `pass` output 1: valid while `done`; 1 when zero mismatches.
- `err_cnt` output 4: number of mismatching vectors, 0..8.
- `fail_vec` output 3: {input1,input2,input3} of first mismatch; 0 if none.

## Operation
- Reset values: input1/2/3=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, state IDLE, vec=0, tcnt=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1: RUN; vec<=0, inputs<=000, tcnt<=0, busy<=1, done<=0, pass<=0, err_cnt<=0, fail_vec<=0.
- RUN, tcnt<SETTLE: tcnt<=tcnt+1, inputs held.
- RUN, tcnt==SETTLE: compare. Golden sum = i1^i2^i3; golden count = majority(i1,i2,i3). Mismatch if either bit differs. On mismatch err_cnt<=err_cnt+1; fail_vec<=vec if first mismatch.
  - vec<7: vec<=vec+1, inputs<=vec+1, tcnt<=0.
  - vec==7: DONE; busy<=0, done<=1, pass<=(final err_cnt==0), inputs<=000.
- DONE: results held; `start` restarts as from IDLE.
- `start` during RUN: ignored.
- `rst` any time, including mid-run: all outputs to reset values next edge, state IDLE; dominates `start`.
- Vector order 000,001,...,111; vec is 3 bits, no wrap beyond 7.
- `sum`/`count` sampled combinationally at the compare edge; no internal synchronizer, same clock domain.

## Timing
- Start sampled at edge k: inputs=000 and busy=1 after edge k.
- Per vector: SETTLE+1 cycles. Compare for vector n at edge k+(n+1)(SETTLE+1).
- Completion at edge k+8(SETTLE+1): done=1, busy=0, pass/err_cnt/fail_vec final after that edge.
- SETTLE=0: busy high 8 cycles, done at k+8.
- Outputs are all registered; no combinational path from `sum`/`count` to any output.

## Configuration
- `FA_BIST_STOP_ON_FAIL_EN` defined: first mismatch goes straight to DONE at that compare edge; err_cnt=1, pass=0, fail_vec=failing vector, inputs<=000, remaining vectors skipped.
- Undefined (default): all 8 vectors always run; err_cnt counts every mismatch.

## Test plan
- Correct `full_adder`, SETTLE=0, start at edge k -> busy edges k..k+8, done=1 after k+8, pass=1, err_cnt=0, fail_vec=0; inputs step 000..111 one per cycle.
- Model with `sum` stuck-at-0, macro undefined -> err_cnt=4 (vectors 001,010,100,111), fail_vec=3'b001, pass=0; with `FA_BIST_STOP_ON_FAIL_EN` -> done after k+2, err_cnt=1, fail_vec=3'b001.
- Model with `count` inverted, SETTLE=2 -> done after edge k+24, err_cnt=8, fail_vec=3'b000, pass=0; each vector held 3 cycles.
- `rst` asserted at edge k+4 of a run -> after that edge busy=0, done=0, err_cnt=0, inputs=000; no further vector change until next `start`.
- `start` re-pulsed at edge k+3 during RUN -> ignored, completion still at k+8; `start` pulsed in DONE -> done clears next edge, fresh run with err_cnt=0.
